// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-switch sequencer: FSM state encoding,
// parameter defaults and the reset image of the registered control outputs.
package pwr_seq_pkg;

  localparam int N_STAGES_DEF = 4;
  localparam int DLY_W_DEF    = 8;
  localparam int ACK_TMO_DEF  = 64;

  typedef enum logic [3:0] {
    ST_OFF        = 4'd0,
    ST_SW_UP      = 4'd1,
    ST_WAIT_ACK   = 4'd2,
    ST_RST_REL    = 4'd3,
    ST_RESTORE    = 4'd4,
    ST_ON         = 4'd5,
    ST_ISO_SET    = 4'd6,
    ST_SAVE       = 4'd7,
    ST_RST_ASSERT = 4'd8,
    ST_SW_DOWN    = 4'd9,
    ST_ERR        = 4'd10
  } pwr_state_t;

  typedef struct packed {
    logic iso_en;
    logic ret_save;
    logic ret_restore;
    logic rst_dom_n;
    logic pwr_good;
    logic busy;
    logic timeout_err;
  } pwr_out_t;

  localparam pwr_out_t OUT_RST = '{
    iso_en:      1'b1,
    ret_save:    1'b0,
    ret_restore: 1'b0,
    rst_dom_n:   1'b0,
    pwr_good:    1'b0,
    busy:        1'b0,
    timeout_err: 1'b0
  };

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable saturating down-counter; tc is high while the count sits at zero.
// Shared between stage spacing and the switch-acknowledge timeout.
module pwr_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_r;

  // Counter: load wins, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == '0);

endmodule

// File: rtl/pwr_switch_sequencer.sv
// Power-domain sequencer: staged header-switch turn-on/off, isolation, retention
// save/restore and domain reset. Outputs are registered from the current state.
module pwr_switch_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int DLY_W    = DLY_W_DEF,
  parameter int ACK_TMO  = ACK_TMO_DEF
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic                PWR_REQ,
  input  logic [DLY_W-1:0]    STAGE_DLY,
  input  logic                SW_ACK,
  output logic [N_STAGES-1:0] SW_EN,
  output logic                ISO_EN,
  output logic                RET_SAVE,
  output logic                RET_RESTORE,
  output logic                RST_DOM_N,
  output logic                PWR_GOOD,
  output logic                BUSY,
  output logic                TIMEOUT_ERR
);

  localparam int ACK_W = $clog2(ACK_TMO);
  localparam int TW    = (DLY_W > ACK_W) ? DLY_W : ACK_W;
  localparam logic [TW-1:0]       TW_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]       ACK_VAL = TW'(ACK_TMO - 1);
  localparam logic [DLY_W-1:0]    D_ONE   = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [N_STAGES-1:0] SW_ONE  = {{(N_STAGES-1){1'b0}}, 1'b1};

  pwr_state_t          state_r, state_s;
  logic [DLY_W-1:0]    d_r, dly_sat_s;
  logic                d_load_s;
  logic                tmr_load_s, tc_s;
  logic [TW-1:0]       tmr_val_s, stage_val_s;
  logic [N_STAGES-1:0] sw_en_r, sw_en_s;
  pwr_out_t            out_r, out_s;

  assign dly_sat_s   = (STAGE_DLY == '0) ? D_ONE : STAGE_DLY;
  assign stage_val_s = TW'(d_r) - TW_ONE;

  pwr_seq_timer #(.W(TW)) u_timer (
    .clk      (CLK),
    .rst_n    (RN),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tc_s)
  );

  // Next-state and timer control; the timer is zeroed on entry to a switch ramp
  // so the first stage moves on the very next edge.
  always_comb begin
    state_s    = state_r;
    d_load_s   = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    case (state_r)
      ST_OFF: begin
        if (PWR_REQ) begin
          state_s    = ST_SW_UP;
          d_load_s   = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_SW_UP: begin
        if (sw_en_r[N_STAGES-1]) begin
          state_s    = ST_WAIT_ACK;
          tmr_load_s = 1'b1;
          tmr_val_s  = ACK_VAL;
        end else if (tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = stage_val_s;
        end else begin
          state_s = ST_SW_UP;
        end
      end
      ST_WAIT_ACK: begin
        if (SW_ACK) begin
          state_s = ST_RST_REL;
        end else if (tc_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_RST_REL:  state_s = ST_RESTORE;
      ST_RESTORE:  state_s = ST_ON;
      ST_ON: begin
        if (!PWR_REQ) begin
          state_s = ST_ISO_SET;
        end else begin
          state_s = ST_ON;
        end
      end
      ST_ISO_SET:  state_s = ST_SAVE;
      ST_SAVE:     state_s = ST_RST_ASSERT;
      ST_RST_ASSERT: begin
        state_s    = ST_SW_DOWN;
        d_load_s   = 1'b1;
        tmr_load_s = 1'b1;
      end
      ST_SW_DOWN: begin
        if (tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = stage_val_s;
          if (sw_en_r <= SW_ONE) begin
            state_s = ST_OFF;
          end else begin
            state_s = ST_SW_DOWN;
          end
        end else begin
          state_s = ST_SW_DOWN;
        end
      end
      ST_ERR: begin
        if (!PWR_REQ) begin
          state_s = ST_OFF;
        end else begin
          state_s = ST_ERR;
        end
      end
      default: state_s = ST_OFF;
    endcase
  end

  // Output image for the next edge; a timeout drops every switch on the same edge.
  always_comb begin
    sw_en_s = sw_en_r;
    out_s   = OUT_RST;
    case (state_r)
      ST_OFF: sw_en_s = '0;
      ST_SW_UP: begin
        out_s.busy = 1'b1;
        if (tc_s && !sw_en_r[N_STAGES-1]) begin
          sw_en_s = {sw_en_r[N_STAGES-2:0], 1'b1};
        end else begin
          sw_en_s = sw_en_r;
        end
      end
      ST_WAIT_ACK: begin
        out_s.busy = 1'b1;
        if (!SW_ACK && tc_s) begin
          sw_en_s           = '0;
          out_s.timeout_err = 1'b1;
        end else begin
          sw_en_s = sw_en_r;
        end
      end
      ST_RST_REL: begin
        out_s.busy      = 1'b1;
        out_s.rst_dom_n = 1'b1;
      end
      ST_RESTORE: begin
        out_s.busy        = 1'b1;
        out_s.rst_dom_n   = 1'b1;
        out_s.ret_restore = 1'b1;
      end
      ST_ON: begin
        out_s.iso_en    = 1'b0;
        out_s.rst_dom_n = 1'b1;
        out_s.pwr_good  = 1'b1;
      end
      ST_ISO_SET: begin
        out_s.busy      = 1'b1;
        out_s.rst_dom_n = 1'b1;
      end
      ST_SAVE: begin
        out_s.busy      = 1'b1;
        out_s.rst_dom_n = 1'b1;
        out_s.ret_save  = 1'b1;
      end
      ST_RST_ASSERT: out_s.busy = 1'b1;
      ST_SW_DOWN: begin
        out_s.busy = 1'b1;
        if (tc_s) begin
          sw_en_s = {1'b0, sw_en_r[N_STAGES-1:1]};
        end else begin
          sw_en_s = sw_en_r;
        end
      end
      ST_ERR: begin
        out_s.busy        = 1'b1;
        out_s.timeout_err = 1'b1;
        sw_en_s           = '0;
      end
      default: sw_en_s = '0;
    endcase
  end

  // State, latched stage delay and output registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_r <= ST_OFF;
      d_r     <= D_ONE;
      sw_en_r <= '0;
      out_r   <= OUT_RST;
    end else begin
      state_r <= state_s;
      if (d_load_s) begin
        d_r <= dly_sat_s;
      end else begin
        d_r <= d_r;
      end
      sw_en_r <= sw_en_s;
      out_r   <= out_s;
    end
  end

  assign SW_EN       = sw_en_r;
  assign ISO_EN      = out_r.iso_en;
  assign RET_SAVE    = out_r.ret_save;
  assign RET_RESTORE = out_r.ret_restore;
  assign RST_DOM_N   = out_r.rst_dom_n;
  assign PWR_GOOD    = out_r.pwr_good;
  assign BUSY        = out_r.busy;
  assign TIMEOUT_ERR = out_r.timeout_err;

endmodule

// File: tb/tb_pwr_switch_sequencer.sv
// Directed bench for pwr_switch_sequencer: reset, power-up/down ramps, request
// reversal, acknowledge timeout, zero stage delay and asynchronous mid-sequence reset.
module tb_pwr_switch_sequencer;

  logic       CLK, RN, PWR_REQ, SW_ACK;
  logic [7:0] STAGE_DLY;
  logic [3:0] SW_EN;
  logic       ISO_EN, RET_SAVE, RET_RESTORE, RST_DOM_N, PWR_GOOD, BUSY, TIMEOUT_ERR;
  logic       clk_on;
  int         n_cmp, n_err;

  pwr_switch_sequencer #(.N_STAGES(4), .DLY_W(8), .ACK_TMO(64)) dut (
    .CLK(CLK), .RN(RN), .PWR_REQ(PWR_REQ), .STAGE_DLY(STAGE_DLY), .SW_ACK(SW_ACK),
    .SW_EN(SW_EN), .ISO_EN(ISO_EN), .RET_SAVE(RET_SAVE), .RET_RESTORE(RET_RESTORE),
    .RST_DOM_N(RST_DOM_N), .PWR_GOOD(PWR_GOOD), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial begin
    CLK = 1'b0;
    wait (clk_on);
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".sw_en"}, 8'(SW_EN), 8'h00);
    chk({tag, ".iso"}, 8'(ISO_EN), 8'd1);
    chk({tag, ".rst_n"}, 8'(RST_DOM_N), 8'd0);
    chk({tag, ".pgood"}, 8'(PWR_GOOD), 8'd0);
    chk({tag, ".busy"}, 8'(BUSY), 8'd0);
    chk({tag, ".tmo"}, 8'(TIMEOUT_ERR), 8'd0);
    chk({tag, ".save"}, 8'(RET_SAVE), 8'd0);
    chk({tag, ".restore"}, 8'(RET_RESTORE), 8'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; clk_on = 1'b0;
    RN = 1'b1; PWR_REQ = 1'b0; SW_ACK = 1'b0; STAGE_DLY = 8'd4;

    // Reset with no clock edges at all
    #1 RN = 1'b0;
    #1 chk_reset_vals("rst");
    clk_on = 1'b1;
    step(); step();
    RN = 1'b1;
    step(); step();
    chk("off_idle.busy", 8'(BUSY), 8'd0);

    // Power-up, D=4; ack first sampled high at edge 16; STAGE_DLY change ignored
    PWR_REQ = 1'b1;
    step();
    chk("up0.busy", 8'(BUSY), 8'd0);
    for (int c = 1; c <= 19; c++) begin
      step();
      if (c == 3) STAGE_DLY = 8'd9;
      if (c == 15) SW_ACK = 1'b1;
      case (c)
        1:  begin chk("up1.sw", 8'(SW_EN), 8'h01); chk("up1.busy", 8'(BUSY), 8'd1); end
        4:  chk("up4.sw", 8'(SW_EN), 8'h01);
        5:  chk("up5.sw", 8'(SW_EN), 8'h03);
        9:  chk("up9.sw", 8'(SW_EN), 8'h07);
        12: chk("up12.sw", 8'(SW_EN), 8'h07);
        13: chk("up13.sw", 8'(SW_EN), 8'h0F);
        16: chk("up16.rst_n", 8'(RST_DOM_N), 8'd0);
        17: begin chk("up17.rst_n", 8'(RST_DOM_N), 8'd1); chk("up17.restore", 8'(RET_RESTORE), 8'd0); end
        18: begin chk("up18.restore", 8'(RET_RESTORE), 8'd1); chk("up18.pgood", 8'(PWR_GOOD), 8'd0); end
        19: begin
          chk("up19.restore", 8'(RET_RESTORE), 8'd0);
          chk("up19.iso", 8'(ISO_EN), 8'd0);
          chk("up19.pgood", 8'(PWR_GOOD), 8'd1);
          chk("up19.busy", 8'(BUSY), 8'd0);
        end
        default: ;
      endcase
    end
    SW_ACK = 1'b0;
    STAGE_DLY = 8'd4;
    step(); step();
    chk("on_hold.pgood", 8'(PWR_GOOD), 8'd1);

    // Power-down, D=4; a later STAGE_DLY change must not alter the spacing
    PWR_REQ = 1'b0;
    step();
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 5) STAGE_DLY = 8'd2;
      case (k)
        1:  begin chk("dn1.iso", 8'(ISO_EN), 8'd1); chk("dn1.pgood", 8'(PWR_GOOD), 8'd0); chk("dn1.busy", 8'(BUSY), 8'd1); end
        2:  begin chk("dn2.save", 8'(RET_SAVE), 8'd1); chk("dn2.rst_n", 8'(RST_DOM_N), 8'd1); end
        3:  begin chk("dn3.save", 8'(RET_SAVE), 8'd0); chk("dn3.rst_n", 8'(RST_DOM_N), 8'd0); chk("dn3.sw", 8'(SW_EN), 8'h0F); end
        4:  chk("dn4.sw", 8'(SW_EN), 8'h07);
        7:  chk("dn7.sw", 8'(SW_EN), 8'h07);
        8:  chk("dn8.sw", 8'(SW_EN), 8'h03);
        12: chk("dn12.sw", 8'(SW_EN), 8'h01);
        16: begin chk("dn16.sw", 8'(SW_EN), 8'h00); chk("dn16.busy", 8'(BUSY), 8'd1); end
        17: chk("dn17.busy", 8'(BUSY), 8'd0);
        default: ;
      endcase
    end

    // Request reversal at cycle 6: power-up still completes, then powers down
    STAGE_DLY = 8'd4;
    PWR_REQ = 1'b1;
    step();
    for (int c = 1; c <= 36; c++) begin
      step();
      if (c == 6) PWR_REQ = 1'b0;
      if (c == 15) SW_ACK = 1'b1;
      if (c == 19) SW_ACK = 1'b0;
      case (c)
        13: chk("rev13.sw", 8'(SW_EN), 8'h0F);
        19: begin chk("rev19.pgood", 8'(PWR_GOOD), 8'd1); chk("rev19.iso", 8'(ISO_EN), 8'd0); end
        20: begin chk("rev20.iso", 8'(ISO_EN), 8'd1); chk("rev20.pgood", 8'(PWR_GOOD), 8'd0); chk("rev20.busy", 8'(BUSY), 8'd1); end
        36: begin chk("rev36.busy", 8'(BUSY), 8'd0); chk("rev36.sw", 8'(SW_EN), 8'h00); end
        default: ;
      endcase
    end

    // Acknowledge timeout, D=1: WAIT_ACK entered at edge 5, error at edge 69
    STAGE_DLY = 8'd1;
    PWR_REQ = 1'b1;
    step();
    for (int c = 1; c <= 72; c++) begin
      step();
      case (c)
        4:  chk("tmo4.sw", 8'(SW_EN), 8'h0F);
        68: begin chk("tmo68.err", 8'(TIMEOUT_ERR), 8'd0); chk("tmo68.sw", 8'(SW_EN), 8'h0F); end
        69: begin
          chk("tmo69.err", 8'(TIMEOUT_ERR), 8'd1);
          chk("tmo69.sw", 8'(SW_EN), 8'h00);
          chk("tmo69.busy", 8'(BUSY), 8'd1);
          chk("tmo69.iso", 8'(ISO_EN), 8'd1);
        end
        72: chk("tmo72.err", 8'(TIMEOUT_ERR), 8'd1);
        default: ;
      endcase
    end
    PWR_REQ = 1'b0;
    step();
    chk("tmo_exit.err", 8'(TIMEOUT_ERR), 8'd1);
    step();
    chk("tmo_off.err", 8'(TIMEOUT_ERR), 8'd0);
    chk("tmo_off.busy", 8'(BUSY), 8'd0);

    // STAGE_DLY=0 acts as 1; early ack accepted in first WAIT_ACK cycle; async reset
    STAGE_DLY = 8'd0;
    SW_ACK = 1'b1;
    PWR_REQ = 1'b1;
    step();
    for (int c = 1; c <= 7; c++) begin
      step();
      case (c)
        2: chk("z2.sw", 8'(SW_EN), 8'h03);
        3: chk("z3.sw", 8'(SW_EN), 8'h07);
        4: chk("z4.sw", 8'(SW_EN), 8'h0F);
        6: chk("z6.rst_n", 8'(RST_DOM_N), 8'd0);
        7: chk("z7.rst_n", 8'(RST_DOM_N), 8'd1);
        default: ;
      endcase
    end
    #2 RN = 1'b0;
    #1 chk_reset_vals("arst");
    PWR_REQ = 1'b0;
    SW_ACK = 1'b0;
    step();
    RN = 1'b1;
    step(); step(); step();
    chk("post_rst.busy", 8'(BUSY), 8'd0);
    chk("post_rst.sw", 8'(SW_EN), 8'h00);
    chk("post_rst.iso", 8'(ISO_EN), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
